// File: rtl/lsu_wb_writeback.sv
// RV32I load/store unit: one Wishbone classic cycle per op, load alignment and
// extension, and a single-cycle register-file writeback strobe.
module lsu_wb_writeback #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        rf_reg_write,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_data_write,
  output logic        fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  typedef enum logic [1:0] {IDLE, BUS, WB} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t          state_q;
  logic [TO_W-1:0] to_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic [4:0]      rd_q;
  logic [31:0]     addr_q;

  logic            cyc_q, stb_q, wwe_q;
  logic [31:0]     adr_q, wdat_q;
  logic [3:0]      sel_q;
  logic            rfw_q;
  logic [4:0]      rfwa_q;
  logic [31:0]     rfd_q;
  logic            fault_q;
  logic [31:0]     faddr_q;

  logic            accept;
  logic            req_bad;
  logic [3:0]      req_sel;
  logic [31:0]     req_dat;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);

  // Decode the offered op: byte selects, lane-replicated store data, legality.
  always_comb begin
    req_bad = 1'b0;
    req_sel = 4'b0000;
    req_dat = 32'h0;
    case (req_funct3)
      3'b000, 3'b100: begin
        req_sel = 4'b0001 << req_addr[1:0];
        req_dat = {4{req_wdata[7:0]}};
        req_bad = req_we && req_funct3[2];
      end
      3'b001, 3'b101: begin
        req_sel = req_addr[1] ? 4'b1100 : 4'b0011;
        req_dat = {2{req_wdata[15:0]}};
        req_bad = req_addr[0] || (req_we && req_funct3[2]);
      end
      3'b010: begin
        req_sel = 4'b1111;
        req_dat = req_wdata;
        req_bad = (req_addr[1:0] != 2'b00);
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load lane selection and extension from the live bus data.
  assign ld_byte = wb_dat_i[{alo_q, 3'b000} +: 8];
  assign ld_half = wb_dat_i[{alo_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = wb_dat_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      to_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      alo_q   <= 2'b00;
      rd_q    <= 5'd0;
      addr_q  <= 32'h0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      wwe_q   <= 1'b0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'b0000;
      rfw_q   <= 1'b0;
      rfwa_q  <= 5'd0;
      rfd_q   <= 32'h0;
      fault_q <= 1'b0;
      faddr_q <= 32'h0;
    end else begin
      // A fault raised below in the same cycle overrides this clear.
      if (fault_clr) fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              fault_q <= 1'b1;
              faddr_q <= req_addr;
            end else begin
              state_q <= BUS;
              to_q    <= TO_ONE;
              we_q    <= req_we;
              f3_q    <= req_funct3;
              alo_q   <= req_addr[1:0];
              rd_q    <= req_rd;
              addr_q  <= req_addr;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              wwe_q   <= req_we;
              adr_q   <= {req_addr[31:2], 2'b00};
              wdat_q  <= req_dat;
              sel_q   <= req_sel;
            end
          end
        end
        BUS: begin
          if (wb_err_i || (!wb_ack_i && to_q == TO_MAX) || wb_ack_i) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            wwe_q  <= 1'b0;
            adr_q  <= 32'h0;
            wdat_q <= 32'h0;
            sel_q  <= 4'b0000;
          end
          if (wb_err_i || (!wb_ack_i && to_q == TO_MAX)) begin
            fault_q <= 1'b1;
            faddr_q <= addr_q;
            state_q <= IDLE;
          end else if (wb_ack_i) begin
            if (we_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= WB;
              rfw_q   <= (rd_q != 5'd0);
              rfwa_q  <= rd_q;
              rfd_q   <= ld_ext;
            end
          end else begin
            to_q <= to_q + TO_ONE;
          end
        end
        WB: begin
          state_q <= IDLE;
          rfw_q   <= 1'b0;
          rfwa_q  <= 5'd0;
          rfd_q   <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = wwe_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wdat_q;
  assign wb_sel_o      = sel_q;
  assign rf_reg_write  = rfw_q;
  assign rf_wa         = rfwa_q;
  assign rf_data_write = rfd_q;
  assign fault         = fault_q;
  assign fault_addr    = faddr_q;

endmodule

// File: tb/tb_lsu_wb_writeback.sv
// Directed bench for lsu_wb_writeback: loads, stores, faults, timeout, reset.
module tb_lsu_wb_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;
  logic        rf_reg_write;
  logic [4:0]  rf_wa;
  logic [31:0] rf_data_write;
  logic        fault, fault_clr;
  logic [31:0] fault_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_wb_writeback #(.TIMEOUT_CYCLES(255), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .rf_reg_write(rf_reg_write), .rf_wa(rf_wa), .rf_data_write(rf_data_write),
    .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdat, input int waits,
                         input logic [3:0] esel, input logic [31:0] edata);
    offer(1'b0, f3, addr, 32'h0, rd);
    chk({tag, " cyc"}, wb_cyc_o, 1);
    chk({tag, " stb"}, wb_stb_o, 1);
    chk({tag, " we"}, wb_we_o, 0);
    chk({tag, " adr"}, wb_adr_o, {addr[31:2], 2'b00});
    chk({tag, " sel"}, wb_sel_o, esel);
    chk({tag, " busy"}, req_ready, 0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, " hold cyc"}, wb_cyc_o, 1);
      chk({tag, " hold sel"}, wb_sel_o, esel);
    end
    wb_ack_i = 1'b1; wb_dat_i = rdat;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk({tag, " cyc drop"}, wb_cyc_o, 0);
    chk({tag, " rf_we"}, rf_reg_write, (rd != 5'd0) ? 1 : 0);
    chk({tag, " rf_wa"}, rf_wa, rd);
    chk({tag, " rf_data"}, rf_data_write, edata);
    chk({tag, " ready in wb"}, req_ready, 0);
    tick();
    chk({tag, " rf_we off"}, rf_reg_write, 0);
    chk({tag, " rf_data off"}, rf_data_write, 0);
    chk({tag, " ready"}, req_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] esel,
                          input logic [31:0] edat);
    offer(1'b1, f3, addr, wdata, 5'd7);
    chk({tag, " cyc"}, wb_cyc_o, 1);
    chk({tag, " we"}, wb_we_o, 1);
    chk({tag, " adr"}, wb_adr_o, {addr[31:2], 2'b00});
    chk({tag, " sel"}, wb_sel_o, esel);
    chk({tag, " dat"}, wb_dat_o, edat);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk({tag, " cyc drop"}, wb_cyc_o, 0);
    chk({tag, " ready"}, req_ready, 1);
    chk({tag, " no rf"}, rf_reg_write, 0);
  endtask

  initial begin
    int cyc_cnt;
    int saw_rf;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; fault_clr = 1'b0;
    tick();
    chk("rst ready", req_ready, 1);
    chk("rst cyc", wb_cyc_o, 0);
    chk("rst stb", wb_stb_o, 0);
    chk("rst rf_we", rf_reg_write, 0);
    chk("rst fault", fault, 0);
    chk("rst fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    tick();

    do_load("LW", 3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF);
    do_load("LW0", 3'b010, 32'h104, 5'd5, 32'h01234567, 0, 4'b1111, 32'h01234567);
    do_load("LB", 3'b000, 32'h103, 5'd3, 32'h80FFFF7F, 0, 4'b1000, 32'hFFFFFF80);
    do_load("LBU", 3'b100, 32'h103, 5'd4, 32'h80FFFF7F, 0, 4'b1000, 32'h00000080);
    do_load("LB0", 3'b000, 32'h100, 5'd6, 32'h80FFFF7F, 0, 4'b0001, 32'h0000007F);
    do_load("LH", 3'b001, 32'h102, 5'd8, 32'h80FFFF7F, 0, 4'b1100, 32'hFFFF80FF);
    do_load("LHU", 3'b101, 32'h100, 5'd9, 32'h80FFFF7F, 0, 4'b0011, 32'h0000FF7F);
    do_load("LWrd0", 3'b010, 32'h108, 5'd0, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D);

    do_store("SH", 3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    do_store("SB", 3'b000, 32'h101, 32'h00000055, 4'b0010, 32'h55555555);
    do_store("SW", 3'b010, 32'h104, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

    // Misaligned word load: no bus cycle, sticky fault.
    offer(1'b0, 3'b010, 32'h101, 32'h0, 5'd5);
    chk("mis cyc", wb_cyc_o, 0);
    chk("mis fault", fault, 1);
    chk("mis fault_addr", fault_addr, 32'h101);
    chk("mis ready", req_ready, 1);
    tick();
    chk("mis sticky", fault, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr fault", fault, 0);

    // Illegal store funct3 together with fault_clr: new fault wins.
    fault_clr = 1'b1;
    offer(1'b1, 3'b011, 32'h200, 32'h0, 5'd0);
    fault_clr = 1'b0;
    chk("ill st cyc", wb_cyc_o, 0);
    chk("ill st fault", fault, 1);
    chk("ill st addr", fault_addr, 32'h200);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    offer(1'b0, 3'b110, 32'h204, 32'h0, 5'd1);
    chk("ill ld cyc", wb_cyc_o, 0);
    chk("ill ld fault", fault, 1);
    chk("ill ld addr", fault_addr, 32'h204);
    offer(1'b1, 3'b001, 32'h207, 32'h0, 5'd1);
    chk("mis sh addr", fault_addr, 32'h207);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr2 fault", fault, 0);

    // Timeout: cyc held for exactly 255 cycles, then abort.
    offer(1'b0, 3'b010, 32'h300, 32'h0, 5'd2);
    cyc_cnt = 0;
    saw_rf = 0;
    for (int i = 0; i < 300 && wb_cyc_o; i++) begin
      cyc_cnt++;
      tick();
      if (rf_reg_write) saw_rf = 1;
    end
    chk("to cyc cycles", cyc_cnt, 255);
    chk("to cyc", wb_cyc_o, 0);
    chk("to fault", fault, 1);
    chk("to fault_addr", fault_addr, 32'h300);
    chk("to ready", req_ready, 1);
    tick();
    chk("to no rf", saw_rf | rf_reg_write, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;

    // Bus error with simultaneous ack: error wins, no writeback.
    offer(1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
    tick();
    chk("err hold cyc", wb_cyc_o, 1);
    wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h11111111;
    tick();
    wb_err_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk("err cyc", wb_cyc_o, 0);
    chk("err stb", wb_stb_o, 0);
    chk("err fault", fault, 1);
    chk("err fault_addr", fault_addr, 32'h400);
    chk("err no rf", rf_reg_write, 0);
    chk("err ready", req_ready, 1);
    tick();
    chk("err no rf2", rf_reg_write, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;

    // Async reset in the middle of a bus cycle.
    offer(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
    chk("rstbus cyc pre", wb_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus cyc", wb_cyc_o, 0);
    chk("rstbus stb", wb_stb_o, 0);
    chk("rstbus ready", req_ready, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    rst_n = 1'b1;
    tick();
    chk("rstbus no rf", rf_reg_write, 0);
    chk("rstbus idle cyc", wb_cyc_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
